// File: rtl/mau_seq_pkg.sv
// Shared types and default sizing for the TOP_MAU sequencer.
package mau_seq_pkg;

    localparam int DATA_W_DEF      = 24;
    localparam int DEPTH_DEF       = 4;
    localparam int WORK_CYCLES_DEF = 6;
    localparam int GAP_CYCLES_DEF  = 2;
    localparam int PTR_W_DEF       = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF       = PTR_W_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/mau_seq_ctrl_if.sv
// Bus between the LBUS/control side (master) and the sequencer (slave), plus MAU-side outputs.
interface mau_seq_ctrl_if #(
    parameter int DATA_W = mau_seq_pkg::DATA_W_DEF,
    parameter int DEPTH  = mau_seq_pkg::DEPTH_DEF
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // op_wr is a single-cycle push with no ready: it lands when op_full is low (or a pop
    // happens in the same cycle); otherwise it is dropped and err latches high.
    logic                start;
    logic                op_wr;
    logic [DATA_W-1:0]   op_a_in;
    logic [DATA_W-1:0]   op_b_in;
    logic                op_full;
    logic [CNT_W-1:0]    op_count;
    logic [DATA_W-1:0]   mau_a;
    logic [DATA_W-1:0]   mau_b;
    logic                mau_enable;
    logic                busy;
    logic                done;
    logic                trig_out;
    logic                err;
    mau_seq_pkg::state_t dbg_state;

    modport master (
        output start, op_wr, op_a_in, op_b_in,
        input  op_full, op_count, mau_a, mau_b, mau_enable, busy, done, trig_out, err, dbg_state
    );

    modport slave (
        input  start, op_wr, op_a_in, op_b_in,
        output op_full, op_count, mau_a, mau_b, mau_enable, busy, done, trig_out, err, dbg_state
    );

endinterface

// File: rtl/mau_op_fifo.sv
// Synchronous operand FIFO; the read side is a combinational peek at head + offset.
module mau_op_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    input  logic [$clog2(DEPTH)-1:0] i_peek_off,
    output logic [W-1:0]             o_peek,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_peek_idx;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_do_pop   = i_pop && !o_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    assign w_peek_idx = r_rd_ptr + i_peek_off;
    assign o_peek     = r_mem[w_peek_idx];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mau_seq_ctrl.sv
// Runs each queued (a,b) pair through TOP_MAU with a fixed enable window and a quiet gap.
// Build option MAU_SEQ_REPLAY_EN: every start replays the whole FIFO without consuming it.
module mau_seq_ctrl
    import mau_seq_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WORK_CYCLES = WORK_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input logic           clk,
    input logic           rst,
    mau_seq_ctrl_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (WORK_CYCLES > GAP_CYCLES) ? WORK_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] WORK_LAST = TMR_W'(WORK_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [TMR_W-1:0]    r_tmr;
    logic                r_first;
    logic                r_err;
    logic [DATA_W-1:0]   r_mau_a;
    logic [DATA_W-1:0]   r_mau_b;
    logic                w_push;
    logic                w_pop;
    logic                w_push_err;
    logic                w_start_err;
    logic                w_full;
    logic                w_empty;
    logic                w_has_more;
    logic [PTR_W-1:0]    w_peek_off;
    logic [2*DATA_W-1:0] w_peek;
    logic [CNT_W-1:0]    w_count;
    logic                w_enable;
    logic                w_busy;
    logic                w_done;
    logic                w_trig;

    assign w_start_err = bus.start && (r_state != ST_IDLE);

`ifdef MAU_SEQ_REPLAY_EN
    // Cursor walks the stored entries from the oldest; the FIFO itself is never popped.
    logic [CNT_W-1:0] r_cursor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cursor <= '0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_cursor <= '0;
        end else if (r_state == ST_LOAD) begin
            r_cursor <= r_cursor + CNT_W'(1);
        end
    end

    assign w_pop      = 1'b0;
    assign w_push     = bus.op_wr && (r_state == ST_IDLE);
    assign w_push_err = bus.op_wr && ((r_state != ST_IDLE) || w_full);
    assign w_peek_off = r_cursor[PTR_W-1:0];
    assign w_has_more = (r_cursor < w_count);
`else
    assign w_pop      = (r_state == ST_LOAD);
    assign w_push     = bus.op_wr;
    assign w_push_err = bus.op_wr && w_full && !w_pop;
    assign w_peek_off = '0;
    assign w_has_more = !w_empty;
`endif

    mau_op_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_data     ({bus.op_a_in, bus.op_b_in}),
        .i_peek_off (w_peek_off),
        .o_peek     (w_peek),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = w_empty ? ST_FIN : ST_LOAD;
            ST_LOAD: w_next = ST_RUN;
            ST_RUN:  if (r_tmr == WORK_LAST) w_next = ST_GAP;
            ST_GAP:  if (r_tmr == GAP_LAST) w_next = w_has_more ? ST_LOAD : ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_enable = 1'b0;
        w_done   = 1'b0;
        w_trig   = 1'b0;
        w_busy   = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD: w_trig   = r_first;
            ST_RUN:  w_enable = 1'b1;
            ST_FIN:  w_done   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr   <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
            r_mau_a <= '0;
            r_mau_b <= '0;
        end else begin
            if ((r_state == ST_RUN || r_state == ST_GAP) && w_next == r_state) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end else begin
                r_tmr <= '0;
            end
            // r_first marks pair 0 of a schedule so the scope trigger fires once per start.
            if (r_state == ST_IDLE && bus.start) begin
                r_first <= 1'b1;
            end else if (r_state == ST_LOAD) begin
                r_first <= 1'b0;
            end
            if (r_state == ST_LOAD) begin
                r_mau_a <= w_peek[2*DATA_W-1:DATA_W];
                r_mau_b <= w_peek[DATA_W-1:0];
            end
            if (w_start_err || w_push_err) r_err <= 1'b1;
        end
    end

    assign bus.op_full    = w_full;
    assign bus.op_count   = w_count;
    assign bus.mau_a      = r_mau_a;
    assign bus.mau_b      = r_mau_b;
    assign bus.mau_enable = w_enable;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.trig_out   = w_trig;
    assign bus.err        = r_err;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_mau_seq_ctrl.sv
// Bench for mau_seq_ctrl: directed schedules, window scoreboard, timing and error checks.
module tb_mau_seq_ctrl;
    import mau_seq_pkg::*;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 4;
    localparam int WORK   = 6;
    localparam int GAP    = 2;
    localparam int PW     = 2 * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    mau_seq_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut_if ();

    mau_seq_ctrl #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WORK_CYCLES (WORK),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] cur_exp;
    bit          have_exp = 1'b0;
    bit          prev_en  = 1'b0;
    int          win_len  = 0;
    int          exp_win_len = WORK;
    int          win_cnt = 0, done_cnt = 0, trig_cnt = 0;
    int          last_win_start = -1, last_done = -1, last_trig = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each enable window pops one expected pair; operands are checked every cycle.
    always @(negedge clk) begin
        if (dut_if.mau_enable) begin
            if (!prev_en) begin
                win_cnt++;
                last_win_start = cyc;
                win_len = 0;
                if (exp_q.size() == 0) begin
                    have_exp = 1'b0;
                    n_total++;
                    n_bad++;
                    $display("FAIL window_unexpected: got a window at cycle %0d expected none", cyc);
                end else begin
                    cur_exp  = exp_q.pop_front();
                    have_exp = 1'b1;
                end
            end
            win_len++;
            if (have_exp) check("window_operands", {dut_if.mau_a, dut_if.mau_b}, cur_exp);
        end else if (prev_en) begin
            check("window_len", win_len, exp_win_len);
        end
        if (dut_if.done) begin
            done_cnt++;
            last_done = cyc;
        end
        if (dut_if.trig_out) begin
            trig_cnt++;
            last_trig = cyc;
        end
        prev_en = dut_if.mau_enable;
    end

    task automatic do_reset();
        rst = 1'b1;
        dut_if.start = 1'b0;
        dut_if.op_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_win_len = WORK;
    endtask

    task automatic push(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input bit queue_exp);
        dut_if.op_wr   = 1'b1;
        dut_if.op_a_in = a;
        dut_if.op_b_in = b;
        if (queue_exp) exp_q.push_back({a, b});
        @(posedge clk);
        #1;
        dut_if.op_wr = 1'b0;
    endtask

    task automatic pulse_start(output int t);
        dut_if.start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        dut_if.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!dut_if.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: got busy after 300 cycles expected idle", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by time %0t expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, w0, d0, g0;
        dut_if.start   = 1'b0;
        dut_if.op_wr   = 1'b0;
        dut_if.op_a_in = '0;
        dut_if.op_b_in = '0;
        do_reset();

        check("rst_state", dut_if.dbg_state, ST_IDLE);
        check("rst_busy", dut_if.busy, 0);
        check("rst_enable", dut_if.mau_enable, 0);
        check("rst_done", dut_if.done, 0);
        check("rst_trig", dut_if.trig_out, 0);
        check("rst_err", dut_if.err, 0);
        check("rst_count", dut_if.op_count, 0);
        check("rst_full", dut_if.op_full, 0);
        check("rst_mau_ab", {dut_if.mau_a, dut_if.mau_b}, 0);

`ifndef MAU_SEQ_REPLAY_EN
        // Single pair: trigger T+1, window T+2..T+7, done T+10.
        push(24'h000123, 24'h000456, 1'b1);
        w0 = win_cnt; d0 = done_cnt; g0 = trig_cnt;
        pulse_start(t);
        wait_idle("t1_idle");
        check("t1_trig_cyc", last_trig, t + 1);
        check("t1_trig_cnt", trig_cnt - g0, 1);
        check("t1_win_start", last_win_start, t + 2);
        check("t1_done_cyc", last_done, t + 10);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_windows", win_cnt - w0, 1);
        check("t1_count", dut_if.op_count, 0);
        check("t1_err", dut_if.err, 0);

        // Three pairs: windows every 9 cycles, one trigger, one done at T+28.
        push(24'h111111, 24'h222222, 1'b1);
        push(24'h333333, 24'h444444, 1'b1);
        push(24'hABCDEF, 24'h0F0F0F, 1'b1);
        check("t2_count_pre", dut_if.op_count, 3);
        w0 = win_cnt; d0 = done_cnt; g0 = trig_cnt;
        pulse_start(t);
        wait_idle("t2_idle");
        check("t2_windows", win_cnt - w0, 3);
        check("t2_last_win", last_win_start, t + 20);
        check("t2_done_cyc", last_done, t + 28);
        check("t2_done_cnt", done_cnt - d0, 1);
        check("t2_trig_cnt", trig_cnt - g0, 1);
        check("t2_count", dut_if.op_count, 0);
        check("t2_expq", exp_q.size(), 0);

        // Empty start: done at T+1, no window, no error.
        w0 = win_cnt; d0 = done_cnt;
        pulse_start(t);
        wait_idle("t3_idle");
        check("t3_done_cyc", last_done, t + 1);
        check("t3_done_cnt", done_cnt - d0, 1);
        check("t3_windows", win_cnt - w0, 0);
        check("t3_err", dut_if.err, 0);

        // Overflow: fifth push is dropped and latches err.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(24'h100000 + 24'(i), 24'h200000 + 24'(i), 1'b1);
        check("t4_full", dut_if.op_full, 1);
        check("t4_count_full", dut_if.op_count, 4);
        check("t4_err_pre", dut_if.err, 0);
        push(24'hDEAD00, 24'hBEEF00, 1'b0);
        check("t4_err_ovf", dut_if.err, 1);
        check("t4_count_ovf", dut_if.op_count, 4);

        // Full FIFO, push in the LOAD cycle: legal, count holds, five windows.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(24'h300000 + 24'(i), 24'h400000 + 24'(i), 1'b1);
        w0 = win_cnt; d0 = done_cnt;
        pulse_start(t);
        push(24'h5A5A5A, 24'hA5A5A5, 1'b1);
        check("t4_count_load", dut_if.op_count, 4);
        check("t4_err_load", dut_if.err, 0);
        wait_idle("t4_idle");
        check("t4_windows", win_cnt - w0, 5);
        check("t4_done_cyc", last_done, t + 46);
        check("t4_count_end", dut_if.op_count, 0);
        check("t4_err_end", dut_if.err, 0);
        check("t4_expq", exp_q.size(), 0);

        // Start during RUN sets err; rst in the 3rd RUN cycle aborts with no done.
        do_reset();
        push(24'hC0FFEE, 24'h5A5A5A, 1'b1);
        exp_win_len = 3;
        pulse_start(t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse_start(t);
        check("t5_err_set", dut_if.err, 1);
        check("t5_busy_run", dut_if.busy, 1);
        check("t5_enable_run", dut_if.mau_enable, 1);
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_enable_abort", dut_if.mau_enable, 0);
        check("t5_busy_abort", dut_if.busy, 0);
        check("t5_err_cleared", dut_if.err, 0);
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("t5_no_done", done_cnt - d0, 0);
        exp_win_len = WORK;
`else
        // Replay: two pairs replayed identically on every start, count unchanged.
        push(24'h0A0A0A, 24'h0B0B0B, 1'b0);
        push(24'h0C0C0C, 24'h0D0D0D, 1'b0);
        check("t6_count_pre", dut_if.op_count, 2);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back({24'h0A0A0A, 24'h0B0B0B});
            exp_q.push_back({24'h0C0C0C, 24'h0D0D0D});
            w0 = win_cnt; d0 = done_cnt; g0 = trig_cnt;
            pulse_start(t);
            wait_idle("t6_idle");
            check("t6_windows", win_cnt - w0, 2);
            check("t6_last_win", last_win_start, t + 11);
            check("t6_done_cyc", last_done, t + 19);
            check("t6_done_cnt", done_cnt - d0, 1);
            check("t6_trig_cnt", trig_cnt - g0, 1);
            check("t6_count", dut_if.op_count, 2);
            check("t6_err", dut_if.err, 0);
            check("t6_expq", exp_q.size(), 0);
        end
        // A push while busy is dropped and latches err.
        exp_q.push_back({24'h0A0A0A, 24'h0B0B0B});
        exp_q.push_back({24'h0C0C0C, 24'h0D0D0D});
        w0 = win_cnt;
        pulse_start(t);
        push(24'h777777, 24'h888888, 1'b0);
        check("t6_err_busy_push", dut_if.err, 1);
        wait_idle("t6_idle_b");
        check("t6_count_b", dut_if.op_count, 2);
        check("t6_windows_b", win_cnt - w0, 2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
